multi_pulse_sync: RTL and testbench

MULTI_PULSE_SYNC -- requirements
Module: multi_pulse_sync

---
 rtl/multi_pulse_sync.sv | 85 ++++++++
 tb/tb_multi_pulse_sync.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_pulse_sync.sv
// Multi-channel pulse synchroniser: each channel carries events from clk_src to clk_dst
// over a two-phase req/ack toggle handshake, with a per-channel pending counter and a sticky drop flag.
module multi_pulse_sync #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PEND_W      = 2
) (
  input  logic          clk_src,
  input  logic          clk_dst,
  input  logic          rst_n,
  input  logic [CH-1:0] src_pulse_i,
  input  logic [CH-1:0] src_drop_clr_i,
  output logic [CH-1:0] src_busy_o,
  output logic [CH-1:0] src_drop_o,
  output logic [CH-1:0] dst_pulse_o
);

  localparam logic [PEND_W:0] PMAX = {1'b0, {PEND_W{1'b1}}};

  for (genvar g = 0; g < CH; g++) begin : g_ch
    // clk_src domain state
    logic                   req_tgl;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [PEND_W-1:0]      pend;
    logic                   drop;
    // clk_dst domain state
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   ack_tgl;
    logic                   pulse_q;

    logic                   idle;
    logic                   launch;
    logic [PEND_W:0]        pend_next;

    // One guard bit on pend_next, so the overflow case is visible before saturation.
    always_comb begin
      idle      = (req_tgl == ack_sync[SYNC_STAGES-1]);
      launch    = idle & ((pend != '0) | src_pulse_i[g]);
      pend_next = {1'b0, pend}
                + {{PEND_W{1'b0}}, src_pulse_i[g]}
                - {{PEND_W{1'b0}}, launch};
    end

    always_ff @(posedge clk_src or negedge rst_n) begin
      if (!rst_n) begin
        req_tgl  <= 1'b0;
        ack_sync <= '0;
        pend     <= '0;
        drop     <= 1'b0;
      end else begin
        ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_tgl};
        if (launch) begin
          req_tgl <= ~req_tgl;
        end
        if (pend_next > PMAX) begin
          pend <= PMAX[PEND_W-1:0];
          drop <= 1'b1;
        end else begin
          pend <= pend_next[PEND_W-1:0];
          if (src_drop_clr_i[g]) begin
            drop <= 1'b0;
          end
        end
      end
    end

    // ack_tgl doubles as the edge-detect history: it follows the synchronised req.
    always_ff @(posedge clk_dst or negedge rst_n) begin
      if (!rst_n) begin
        req_sync <= '0;
        ack_tgl  <= 1'b0;
        pulse_q  <= 1'b0;
      end else begin
        req_sync <= {req_sync[SYNC_STAGES-2:0], req_tgl};
        ack_tgl  <= req_sync[SYNC_STAGES-1];
        pulse_q  <= req_sync[SYNC_STAGES-1] ^ ack_tgl;
      end
    end

    assign src_busy_o[g]  = ~idle | (pend != '0);
    assign src_drop_o[g]  = drop;
    assign dst_pulse_o[g] = pulse_q;
  end

endmodule

// File: tb/tb_multi_pulse_sync.sv
// Directed bench for multi_pulse_sync: default instance at 100/25 MHz plus a
// SYNC_STAGES=3 instance at 100/400 MHz for a random event-conservation run.
`timescale 1ns/1ps
module tb_multi_pulse_sync;

  logic       clk_src   = 1'b0;
  logic       clk_dst   = 1'b0;
  logic       clk_dst_b = 1'b0;
  logic       rst_n     = 1'b0;

  logic [3:0] src_pulse_i    = '0;
  logic [3:0] src_drop_clr_i = '0;
  logic [3:0] src_busy_o, src_drop_o, dst_pulse_o;

  logic [3:0] src_pulse_b    = '0;
  logic [3:0] src_drop_clr_b = 4'hF;
  logic [3:0] src_busy_b, src_drop_b, dst_pulse_b;

  int vectors     = 0;
  int miscompares = 0;
  int cnt_a [4]   = '{default: 0};
  int cnt_b [4]   = '{default: 0};
  int snap  [4];
  int sent  [4]   = '{default: 0};
  int drops [4]   = '{default: 0};
  int n;
  logic [31:0] rv;

  always #5    clk_src   = ~clk_src;
  always #20   clk_dst   = ~clk_dst;
  always #1.25 clk_dst_b = ~clk_dst_b;

  multi_pulse_sync #(.CH(4), .SYNC_STAGES(2), .PEND_W(2)) u_dut (
    .clk_src        (clk_src),
    .clk_dst        (clk_dst),
    .rst_n          (rst_n),
    .src_pulse_i    (src_pulse_i),
    .src_drop_clr_i (src_drop_clr_i),
    .src_busy_o     (src_busy_o),
    .src_drop_o     (src_drop_o),
    .dst_pulse_o    (dst_pulse_o)
  );

  multi_pulse_sync #(.CH(4), .SYNC_STAGES(3), .PEND_W(2)) u_dut_b (
    .clk_src        (clk_src),
    .clk_dst        (clk_dst_b),
    .rst_n          (rst_n),
    .src_pulse_i    (src_pulse_b),
    .src_drop_clr_i (src_drop_clr_b),
    .src_busy_o     (src_busy_b),
    .src_drop_o     (src_drop_b),
    .dst_pulse_o    (dst_pulse_b)
  );

  // Each dst cycle with the pulse high counts as one delivered event.
  always @(negedge clk_dst)
    for (int i = 0; i < 4; i++) if (dst_pulse_o[i]) cnt_a[i] <= cnt_a[i] + 1;

  always @(negedge clk_dst_b)
    for (int i = 0; i < 4; i++) if (dst_pulse_b[i]) cnt_b[i] <= cnt_b[i] + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      @(negedge clk_src);
      if (src_busy_o == 4'h0 && src_busy_b == 4'h0) break;
    end
    chk("idle_within_budget", 32'(k < max_cyc), 32'd1);
    repeat (2) @(negedge clk_dst);
  endtask

  task automatic take_snap();
    for (int i = 0; i < 4; i++) snap[i] = cnt_a[i];
  endtask

  initial begin
    #1;
    chk("rst_busy",  32'(src_busy_o),  32'h0);
    chk("rst_drop",  32'(src_drop_o),  32'h0);
    chk("rst_pulse", 32'(dst_pulse_o), 32'h0);
    repeat (3) @(negedge clk_src);
    #2 rst_n = 1'b1;

    // Single pulse on ch0, with launch-to-delivery latency in clk_dst edges.
    @(negedge clk_src);
    take_snap();
    src_pulse_i = 4'b0001;
    @(posedge clk_src);
    #1 src_pulse_i = 4'b0000;
    chk("single_busy", 32'(src_busy_o), 32'h1);
    n = 0;
    while (n < 8) begin
      @(posedge clk_dst);
      n++;
      #1;
      if (dst_pulse_o[0]) break;
    end
    chk("single_latency_3to4", 32'(n >= 3 && n <= 4), 32'd1);
    chk("single_busy_until_ack", 32'(src_busy_o[0]), 32'd1);
    wait_idle(200);
    chk("single_ch0_count", 32'(cnt_a[0] - snap[0]), 32'd1);
    chk("single_others_silent",
        32'((cnt_a[1] - snap[1]) + (cnt_a[2] - snap[2]) + (cnt_a[3] - snap[3])), 32'd0);

    // Five back-to-back pulses on ch1: one launched, three pending, fifth dropped.
    take_snap();
    src_pulse_i = 4'b0010;
    repeat (4) @(negedge clk_src);
    chk("burst_no_drop_at_pmax", 32'(src_drop_o[1]), 32'd0);
    @(negedge clk_src);
    src_pulse_i = 4'b0000;
    chk("burst_drop_set", 32'(src_drop_o[1]), 32'd1);
    wait_idle(600);
    chk("burst_ch1_count", 32'(cnt_a[1] - snap[1]), 32'd4);
    chk("burst_drop_sticky", 32'(src_drop_o), 32'h2);

    src_drop_clr_i = 4'b0010;
    @(negedge clk_src);
    src_drop_clr_i = 4'b0000;
    chk("drop_cleared", 32'(src_drop_o[1]), 32'd0);

    // Clear coinciding with a fresh overflow: the set must win.
    take_snap();
    src_pulse_i = 4'b0010;
    repeat (4) @(negedge clk_src);
    src_drop_clr_i = 4'b0010;
    @(negedge clk_src);
    src_pulse_i    = 4'b0000;
    src_drop_clr_i = 4'b0000;
    chk("clr_vs_set_set_wins", 32'(src_drop_o[1]), 32'd1);
    wait_idle(600);
    chk("clr_vs_set_ch1_count", 32'(cnt_a[1] - snap[1]), 32'd4);
    src_drop_clr_i = 4'b0010;
    @(negedge clk_src);
    src_drop_clr_i = 4'b0000;

    // All channels at once.
    take_snap();
    src_pulse_i = 4'b1111;
    @(negedge clk_src);
    src_pulse_i = 4'b0000;
    chk("all_busy", 32'(src_busy_o), 32'hF);
    wait_idle(200);
    for (int i = 0; i < 4; i++)
      chk($sformatf("all_ch%0d_count", i), 32'(cnt_a[i] - snap[i]), 32'd1);
    chk("all_no_drop", 32'(src_drop_o), 32'h0);

    // Reset with ch2 in flight and two pending.
    take_snap();
    src_pulse_i = 4'b0100;
    repeat (3) @(negedge clk_src);
    src_pulse_i = 4'b0000;
    chk("pre_reset_busy", 32'(src_busy_o), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy",  32'(src_busy_o),  32'h0);
    chk("midreset_drop",  32'(src_drop_o),  32'h0);
    chk("midreset_pulse", 32'(dst_pulse_o), 32'h0);
    repeat (3) @(negedge clk_src);
    #2 rst_n = 1'b1;
    repeat (60) @(negedge clk_src);
    chk("post_reset_ch2_silent", 32'(cnt_a[2] - snap[2]), 32'd0);
    chk("post_reset_idle", 32'(src_busy_o), 32'h0);

    // Random traffic into the SYNC_STAGES=3 instance; clear held high so each
    // cycle showing drop reflects exactly one event discarded at the prior edge.
    chk("b_quiet_before_random", 32'(cnt_b[0] + cnt_b[1] + cnt_b[2] + cnt_b[3]), 32'd0);
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk_src);
      for (int i = 0; i < 4; i++) if (src_drop_b[i]) drops[i]++;
      rv = $urandom;
      src_pulse_b = rv[3:0] & rv[7:4];
      for (int i = 0; i < 4; i++) if (src_pulse_b[i]) sent[i]++;
    end
    @(negedge clk_src);
    for (int i = 0; i < 4; i++) if (src_drop_b[i]) drops[i]++;
    src_pulse_b = 4'b0000;
    wait_idle(400);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rand_ch%0d_delivered_plus_drops", i), 32'(cnt_b[i] + drops[i]), 32'(sent[i]));
    chk("rand_a_untouched", 32'(src_busy_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time budget exceeded");
  end

endmodule
